// File: rtl/pe_inject_ni_pkg.sv
// Shared definitions for the PE injection interface: FSM encoding and
// packet field offset helpers derived from the coordinate/payload widths.
package pe_inject_ni_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ni_state_e;

    // Field offsets, LSB first: dst_y, dst_x, src_y, src_x, payload
    function automatic int unsigned dsty_lsb();
        return 0;
    endfunction

    function automatic int unsigned dstx_lsb(input int unsigned ys);
        return ys;
    endfunction

    function automatic int unsigned srcy_lsb(input int unsigned xs, input int unsigned ys);
        return xs + ys;
    endfunction

    function automatic int unsigned srcx_lsb(input int unsigned xs, input int unsigned ys);
        return xs + 2 * ys;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned xs, input int unsigned ys);
        return 2 * xs + 2 * ys;
    endfunction

endpackage

// File: rtl/pe_inject_ni_fifo.sv
// Small synchronous FIFO holding neuron results; push and pop may coincide
// whenever the FIFO is not full.
module ni_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through a valid head
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/pe_inject_ni.sv
// PE-side injection NI: buffers neuron results and multicasts each one as
// NUM_DEST XY-routed unicast packets down a destination column.
module pe_inject_ni
    import pe_inject_ni_pkg::*;
#(
    parameter int unsigned x_coord     = 1,
    parameter int unsigned y_coord     = 1,
    parameter int unsigned data_width  = 8,
    parameter int unsigned x_size      = 2,
    parameter int unsigned y_size      = 2,
    parameter int unsigned total_width = 2 * x_size + 2 * y_size + data_width,
    parameter int unsigned DEST_X      = 2,
    parameter int unsigned DEST_Y0     = 0,
    parameter int unsigned NUM_DEST    = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [data_width-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [total_width-1:0] o_data_pe,
    output logic                   o_valid_pe,
    input  logic                   i_ready_pe,
    output logic                   busy,
    output logic [15:0]            pkt_count
);

    localparam int unsigned DSTY_LSB = dsty_lsb();
    localparam int unsigned DSTX_LSB = dstx_lsb(y_size);
    localparam int unsigned SRCY_LSB = srcy_lsb(x_size, y_size);
    localparam int unsigned SRCX_LSB = srcx_lsb(x_size, y_size);
    localparam int unsigned DATA_LSB = data_lsb(x_size, y_size);
    localparam int unsigned IDX_W    = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

    ni_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic [data_width-1:0] fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  push, pop, xfer, last;
    logic [y_size-1:0]     dst_y;
    logic [total_width-1:0] pkt;

    assign push = in_valid && !fifo_full;
    assign xfer = (state_q == ST_SEND) && i_ready_pe;
    assign last = (idx_q == IDX_W'(NUM_DEST - 1));
    assign pop  = xfer && last;

    ni_sync_fifo #(
        .WIDTH (data_width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Next state: walk idx across destinations, chain straight into next result
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (!fifo_empty) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    if (last) begin
                        idx_d = '0;
                        if (!push && fifo_count == CW'(1)) state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: packet assembled from FIFO head and current destination index
    always_comb begin
        dst_y = y_size'(DEST_Y0) + y_size'(idx_q);
        pkt   = '0;
        pkt[DSTY_LSB +: y_size]     = dst_y;
        pkt[DSTX_LSB +: x_size]     = x_size'(DEST_X);
        pkt[SRCY_LSB +: y_size]     = y_size'(y_coord);
        pkt[SRCX_LSB +: x_size]     = x_size'(x_coord);
        pkt[DATA_LSB +: data_width] = fifo_head;
        o_valid_pe = (state_q == ST_SEND);
        o_data_pe  = o_valid_pe ? pkt : '0;
        in_ready   = !fifo_full;
        busy       = !fifo_empty || (state_q == ST_SEND);
        pkt_count  = pkt_count_q;
    end

endmodule

// File: tb/tb_pe_inject_ni.sv
// Self-checking bench for pe_inject_ni: scoreboard of expected packets fed on
// accepted pushes and drained as the switch side accepts packets.
module tb_pe_inject_ni;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] o_data_pe;
    logic        o_valid_pe;
    logic        i_ready_pe = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pkts = '0;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    pe_inject_ni dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .o_data_pe  (o_data_pe),
        .o_valid_pe (o_valid_pe),
        .i_ready_pe (i_ready_pe),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    // Scoreboard: node (1,1) -> column x=2, rows 0..3 gives low byte 0x58+d
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                for (int d = 0; d < 4; d++)
                    exp_q.push_back({in_data, 8'h58 + 8'(d)});
                exp_pkts = exp_pkts + 16'd4;
            end
            if (prev_stall) begin
                n_checks++;
                if (!o_valid_pe) begin
                    n_fail++;
                    $display("FAIL valid_hold: o_valid_pe=%0b required 1 after stall", o_valid_pe);
                end
            end
            if (o_valid_pe) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: unexpected packet %h", o_data_pe);
                end else begin
                    if (o_data_pe !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h required %h", o_data_pe, exp_q[0]);
                    end
                    if (i_ready_pe) void'(exp_q.pop_front());
                end
            end
            prev_stall = o_valid_pe && !i_ready_pe;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_pkts = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !o_valid_pe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (o_valid_pe !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            pkt_count !== 16'h0 || o_data_pe !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b busy=%b cnt=%h data=%h required 0 1 0 0000 0000",
                     o_valid_pe, in_ready, busy, pkt_count, o_data_pe);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int first = -1;
        int nv = 0;
        bit ok;
        do_reset();
        i_ready_pe = 1'b1;
        push_one(8'hA5);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_valid_pe) begin
                if (first < 0) first = c;
                nv++;
            end
        end
        n_checks++;
        if (first != 1 || nv != 4) begin
            n_fail++;
            $display("FAIL single_timing: first=%0d count=%0d required 1 4", first, nv);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'd4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: ok=%0b cnt=%0d busy=%b required 1 4 0", ok, pkt_count, busy);
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        i_ready_pe = 1'b1;
        push_one(8'hA5);
        @(posedge clk); @(posedge clk); #1;
        i_ready_pe = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_valid_pe !== 1'b1 || o_data_pe !== 16'hA559) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b data=%h required 1 a559", o_valid_pe, o_data_pe);
            end
            @(posedge clk); #1;
        end
        i_ready_pe = 1'b1;
        wait_idle(20, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'd4) begin
            n_fail++;
            $display("FAIL stall_count: ok=%0b cnt=%0d required 1 4", ok, pkt_count);
        end
    endtask

    task automatic test_back_to_back();
        int run = 0;
        int best = 0;
        bit ok;
        do_reset();
        i_ready_pe = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h11;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            run = o_valid_pe ? run + 1 : 0;
            if (run > best) best = run;
        end
        n_checks++;
        if (best != 8) begin
            n_fail++;
            $display("FAIL b2b_run: longest valid run=%0d required 8", best);
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'd8) begin
            n_fail++;
            $display("FAIL b2b_count: ok=%0b cnt=%0d required 1 8", ok, pkt_count);
        end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        i_ready_pe = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'(8'h61 + k);
            @(negedge clk);
            n_checks++;
            if (in_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL full_ready: push %0d in_ready=%b required %0b", k, in_ready, (k < 4));
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        i_ready_pe = 1'b1;
        wait_idle(60, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'd16 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: ok=%0b cnt=%0d ready=%b required 1 16 1", ok, pkt_count, in_ready);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        bit seen = 1'b0;
        do_reset();
        i_ready_pe = 1'b1;
        push_one(8'h33);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_pkts = '0;
        #1;
        n_checks++;
        if (o_valid_pe !== 1'b0 || pkt_count !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: valid=%b cnt=%h busy=%b required 0 0000 0", o_valid_pe, pkt_count, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        push_one(8'h44);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (o_valid_pe) begin
                seen = 1'b1;
                n_checks++;
                if (o_data_pe !== 16'h4458) begin
                    n_fail++;
                    $display("FAIL midrst_first: data=%h required 4458", o_data_pe);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_timeout: no packet after reset, required 4458");
        end
        wait_idle(20, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'd4) begin
            n_fail++;
            $display("FAIL midrst_count: ok=%0b cnt=%0d required 1 4", ok, pkt_count);
        end
    endtask

    task automatic test_wrap();
        int  pushes = 0;
        int  xfers  = 0;
        bit  done   = 1'b0;
        bit  ok;
        do_reset();
        i_ready_pe = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int c = 0; c < 70000 && !done; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) pushes++;
            if (o_valid_pe && i_ready_pe) xfers++;
            @(posedge clk); #1;
            if (xfers == 65534 && o_valid_pe) begin
                n_checks++;
                if (pkt_count !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL wrap_pre: cnt=%h required fffe", pkt_count);
                end
            end
            if (xfers == 65538) begin
                done = 1'b1;
                n_checks++;
                if (pkt_count !== 16'h0002) begin
                    n_fail++;
                    $display("FAIL wrap_post: cnt=%h required 0002", pkt_count);
                end
            end
            in_valid = (pushes < 16385);
            in_data  = 8'(pushes);
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wrap_timeout: transfers=%0d required 65538", xfers);
        end
        wait_idle(40, ok);
        n_checks++;
        if (!ok || pkt_count !== 16'h0004) begin
            n_fail++;
            $display("FAIL wrap_end: ok=%0b cnt=%h required 1 0004", ok, pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_full();
        test_reset_mid_send();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
